// File: rtl/polyveck_power2round_stream_if.sv
// Coefficient stream into the Power2Round block and the t0 stream out of it.
// A coefficient transfers on any rising edge where coef_valid and coef_ready are both high; t0 is a
// one-cycle pulse (t0_valid) with no back-pressure.
interface polyveck_power2round_stream_if #(
    parameter int COEF_W = 32,
    parameter int IDX_W  = 12
);
    logic              coef_valid;
    logic              coef_ready;
    logic [COEF_W-1:0] coef_in;
    logic              t0_valid;
    logic [COEF_W-1:0] t0_out;
    logic [IDX_W-1:0]  t0_idx;

    modport master (
        output coef_valid,
        output coef_in,
        input  coef_ready,
        input  t0_valid,
        input  t0_out,
        input  t0_idx
    );

    modport slave (
        input  coef_valid,
        input  coef_in,
        output coef_ready,
        output t0_valid,
        output t0_out,
        output t0_idx
    );
endinterface

// File: rtl/polyveck_power2round_stream.sv
// Power2Round over a K*N coefficient stream: t1 is collected into a flat vector for the
// public-key packer, and t0 is streamed out for the secret-key path.
module polyveck_power2round_stream #(
    parameter int K      = 6,
    parameter int N      = 256,
    parameter int D      = 13,
    parameter int Q      = 8380417,
    parameter int COEF_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    polyveck_power2round_stream_if.slave strm,
    output logic [K*N*COEF_W-1:0]   t1_out,
    output logic                    busy,
    output logic                    done,
    output logic                    range_err,
    output logic [1:0]              state_dbg
);
    localparam int IDX_W = 12;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(K*N-1);
    localparam logic [COEF_W:0]   ROUND    = (COEF_W+1)'((1 << (D-1)) - 1);
    localparam logic [COEF_W-1:0] Q_W      = COEF_W'(Q);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic              hs;
    logic [COEF_W:0]   sum;
    logic [COEF_W-1:0] t1;
    logic [COEF_W-1:0] t0;

    assign strm.coef_ready = (state == RUN);
    assign hs              = strm.coef_valid & strm.coef_ready;
    assign busy            = (state == RUN);
    assign done            = (state == DONE);
    assign state_dbg       = state;

    // One extra sum bit keeps inputs near 2^COEF_W from wrapping before the shift.
    always_comb begin
        sum = {1'b0, strm.coef_in} + ROUND;
        t1  = {{(D-1){1'b0}}, sum[COEF_W:D]};
        t0  = strm.coef_in - {t1[COEF_W-1-D:0], {D{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            range_err     <= 1'b0;
            t1_out        <= '0;
            strm.t0_valid <= 1'b0;
            strm.t0_out   <= '0;
            strm.t0_idx   <= '0;
        end else begin
            strm.t0_valid <= hs;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        idx       <= '0;
                        range_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (hs) begin
                        t1_out[idx*COEF_W +: COEF_W] <= t1;
                        strm.t0_out <= t0;
                        strm.t0_idx <= idx;
                        if (strm.coef_in >= Q_W) begin
                            range_err <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_polyveck_power2round_stream.sv
// Directed bench for polyveck_power2round_stream: table of hand-computed vectors, then full
// vectors with random gaps checked against an expected queue, plus reset/start corner cases.
module tb_polyveck_power2round_stream;
    localparam int K     = 6;
    localparam int N     = 256;
    localparam int TOTAL = K * N;
    localparam int Q     = 8380417;
    localparam int W     = 76;
    localparam int NTAB  = 10;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [K*N*32-1:0] t1_out;
    logic busy, done, range_err;
    logic [1:0] state_dbg;

    polyveck_power2round_stream_if #(.COEF_W(32), .IDX_W(12)) strm();

    polyveck_power2round_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .strm      (strm),
        .t1_out    (t1_out),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] t1;
        logic [31:0] t0;
        logic        err;
    } vec_t;

    vec_t        tab[NTAB];
    logic [W-1:0] exp_q[$];
    logic [31:0] exp_t1_arr[TOTAL];
    int          n_cmp = 0;
    int          n_err = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [31:0] a, output logic [31:0] t1, output logic [31:0] t0);
        longint v;
        v  = longint'(a);
        t1 = 32'((v + 4095) / 8192);
        t0 = 32'(v - longint'(t1) * 8192);
    endfunction

    task automatic send_coef(input logic [31:0] a, input int gap);
        logic [31:0] t1, t0;
        int t;
        repeat (gap) @(negedge clk);
        model(a, t1, t0);
        exp_q.push_back({12'(hs_cnt), t0, t1});
        exp_t1_arr[hs_cnt] = t1;
        strm.coef_valid = 1'b1;
        strm.coef_in    = a;
        t = 0;
        while (!strm.coef_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("ready_timeout", 64'(t), 64'd0);
        @(posedge clk);
        hs_cnt++;
        @(negedge clk);
        strm.coef_valid = 1'b0;
    endtask

    task automatic check_t1_full(input string name);
        int bad = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (t1_out[32*i +: 32] !== exp_t1_arr[i]) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scoreboard: every t0 pulse must match the oldest outstanding coefficient.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (done) done_cnt++;
        if (mon_en && strm.t0_valid) begin
            if (exp_q.size() == 0) begin
                check("t0_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("t0_idx", 64'(strm.t0_idx), 64'(e[75:64]));
                check("t0_out", 64'(strm.t0_out), 64'(e[63:32]));
                check("t1_slot", 64'(t1_out[32*int'(strm.t0_idx) +: 32]), 64'(e[31:0]));
            end
        end
    end

    initial begin
        tab[0] = '{32'd0,       32'd0,       32'd0,          1'b0};
        tab[1] = '{32'd4096,    32'd0,       32'd4096,       1'b0};
        tab[2] = '{32'd4097,    32'd1,       32'hFFFF_F001,  1'b0};
        tab[3] = '{32'd4095,    32'd0,       32'd4095,       1'b0};
        tab[4] = '{32'd8191,    32'd1,       32'hFFFF_FFFF,  1'b0};
        tab[5] = '{32'd12288,   32'd1,       32'd4096,       1'b0};
        tab[6] = '{32'd8380416, 32'd1023,    32'd0,          1'b0};
        tab[7] = '{32'd8380417, 32'd1023,    32'd1,          1'b1};
        tab[8] = '{32'd0,       32'd0,       32'd0,          1'b1};
        tab[9] = '{32'hFFFF_FFFF, 32'h0008_0000, 32'hFFFF_FFFF, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        strm.coef_valid = 1'b0;
        strm.coef_in = '0;
        repeat (3) @(negedge clk);
        check("rst_state",     64'(state_dbg), 64'd0);
        check("rst_ready",     64'(strm.coef_ready), 64'd0);
        check("rst_t0_valid",  64'(strm.t0_valid), 64'd0);
        check("rst_t0_out",    64'(strm.t0_out), 64'd0);
        check("rst_t0_idx",    64'(strm.t0_idx), 64'd0);
        check("rst_busy_done", 64'({busy, done, range_err}), 64'd0);
        check("rst_t1_zero",   64'(t1_out == '0), 64'd1);
        rst = 1'b0;

        // Vector 1: table entries first, then random fill.
        pulse_start();
        check("v1_busy",  64'(busy), 64'd1);
        check("v1_ready", 64'(strm.coef_ready), 64'd1);
        check("v1_pre_t0_valid", 64'(strm.t0_valid), 64'd0);
        for (int i = 0; i < NTAB; i++) begin
            @(negedge clk);
            strm.coef_valid = 1'b1;
            strm.coef_in    = tab[i].a;
            exp_t1_arr[i]   = tab[i].t1;
            @(posedge clk);
            #1;
            strm.coef_valid = 1'b0;
            check($sformatf("tab%0d_t0_valid", i), 64'(strm.t0_valid), 64'd1);
            check($sformatf("tab%0d_t0_out", i),   64'(strm.t0_out), 64'(tab[i].t0));
            check($sformatf("tab%0d_t0_idx", i),   64'(strm.t0_idx), 64'(i));
            check($sformatf("tab%0d_t1", i),       64'(t1_out[32*i +: 32]), 64'(tab[i].t1));
            check($sformatf("tab%0d_range_err", i), 64'(range_err), 64'(tab[i].err));
        end
        // Stall: no handshake, nothing moves.
        repeat (3) @(negedge clk);
        check("stall_t0_valid", 64'(strm.t0_valid), 64'd0);
        check("stall_t0_idx",   64'(strm.t0_idx), 64'(NTAB-1));
        check("stall_t1",       64'(t1_out[32*(NTAB-1) +: 32]), 64'(tab[NTAB-1].t1));

        hs_cnt = NTAB;
        done_cnt = 0;
        mon_en = 1'b1;
        for (int i = NTAB; i < TOTAL; i++) begin
            send_coef(32'($urandom_range(0, Q-1)), $urandom_range(0, 2));
        end
        repeat (5) @(negedge clk);
        check("v1_done_once", 64'(done_cnt), 64'd1);
        check("v1_q_empty", 64'(exp_q.size()), 64'd0);
        check("v1_range_err_sticky", 64'(range_err), 64'd1);
        check("v1_idle", 64'({state_dbg, busy}), 64'd0);
        check_t1_full("v1_t1_full");

        // Vector 2: stray start mid-run, then reset after 700 handshakes.
        done_cnt = 0;
        hs_cnt = 0;
        pulse_start();
        check("v2_range_err_cleared", 64'(range_err), 64'd0);
        for (int i = 0; i < 700; i++) begin
            if (i == 300) begin
                pulse_start();
                check("v2_start_in_run", 64'(state_dbg), 64'd1);
            end
            send_coef(32'($urandom_range(0, Q-1)), $urandom_range(0, 2));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_state",    64'(state_dbg), 64'd0);
        check("mid_rst_outs",     64'({strm.coef_ready, strm.t0_valid, busy, done, range_err}), 64'd0);
        check("mid_rst_t0",       64'({strm.t0_out, 20'd0, strm.t0_idx}), 64'd0);
        check("mid_rst_t1_zero",  64'(t1_out == '0), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();

        // coef_valid in IDLE is ignored.
        strm.coef_valid = 1'b1;
        strm.coef_in = 32'd12345;
        repeat (4) @(negedge clk);
        check("idle_ready",   64'(strm.coef_ready), 64'd0);
        check("idle_t0",      64'(strm.t0_valid), 64'd0);
        check("idle_t1_zero", 64'(t1_out == '0), 64'd1);
        strm.coef_valid = 1'b0;

        // rst and start together: reset wins.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start_state", 64'({state_dbg, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start_idle", 64'(state_dbg), 64'd0);
        check("v2_no_done", 64'(done_cnt), 64'd0);

        // Vector 3: clean full vector after the aborted one.
        hs_cnt = 0;
        pulse_start();
        for (int i = 0; i < TOTAL; i++) begin
            send_coef(32'($urandom_range(0, Q-1)), $urandom_range(0, 3));
        end
        repeat (5) @(negedge clk);
        check("v3_done_once", 64'(done_cnt), 64'd1);
        check("v3_q_empty", 64'(exp_q.size()), 64'd0);
        check("v3_range_err", 64'(range_err), 64'd0);
        check_t1_full("v3_t1_full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
